// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver that deframes serial bytes into a first-word-fall-through FIFO.
// Optional feature: define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx #(
    parameter int DataLength      = 8,
    parameter int FifoDepth       = 8,
    parameter int OverSample      = 8,
    parameter int BaudRate        = 115200,
    parameter int SystemClockFreq = 50_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rx,
    input  logic                  i_rx_req,
    output logic [DataLength-1:0] o_rx_data,
    output logic                  o_rx_rdy,
    output logic                  o_busy,
    output logic                  o_frame_err,
    output logic                  o_parity_err,
    output logic                  o_overrun
);
    localparam int DIV = SystemClockFreq / (BaudRate * OverSample);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OverSample);
    localparam int BW  = $clog2(DataLength + 1);
    localparam int AW  = $clog2(FifoDepth);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] T_HALF   = TW'(OverSample / 2 - 1);
    localparam logic [TW-1:0] T_FULL   = TW'(OverSample - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(DataLength - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_rx_s;
    logic [1:0]            r_sv;
    logic                  r_armed;
    logic [DW-1:0]         r_div_cnt;
    logic [TW-1:0]         r_tcnt;
    logic [BW-1:0]         r_bitcnt;
    logic [DataLength-1:0] r_shift;
    logic                  r_frame_err;
    logic                  r_overrun;
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [DataLength-1:0] r_mem [FifoDepth];
`ifdef UART_RX_PARITY_EN
    logic                  r_par_bad;
    logic                  r_parity_err;
`endif

    logic w_tick;
    logic w_start_det;
    logic w_stop_smp;
    logic w_push;
    logic w_pop;
    logic w_wr;
    logic w_empty;
    logic w_full;

    // Two-flop synchronizer; r_sv marks when r_rx_s reflects the real line after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_sv    <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_rx_s  <= r_sync1;
            r_sv    <= {r_sv[0], 1'b1};
            if (r_sv[1] && r_rx_s)
                r_armed <= 1'b1;
        end
    end

    // Armed only after a genuine high has been seen, so a line held low through reset is ignored.
    assign w_start_det = (r_state == S_IDLE) && r_armed && !r_rx_s;
    assign w_tick      = (r_div_cnt == DIV_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_div_cnt <= '0;
        else if (w_start_det || w_tick)
            r_div_cnt <= '0;
        else
            r_div_cnt <= r_div_cnt + 1'b1;
    end

    assign w_stop_smp = (r_state == S_STOP) && w_tick && (r_tcnt == T_FULL);
`ifdef UART_RX_PARITY_EN
    assign w_push     = w_stop_smp && r_rx_s && !r_par_bad;
`else
    assign w_push     = w_stop_smp && r_rx_s;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_tcnt      <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_start_det) begin
                        r_tcnt  <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tcnt == T_HALF) begin
                            if (r_rx_s) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_tcnt   <= '0;
                                r_bitcnt <= '0;
`ifdef UART_RX_PARITY_EN
                                r_par_bad <= 1'b0;
`endif
                                r_state  <= S_DATA;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tcnt == T_FULL) begin
                            r_tcnt   <= '0;
                            r_shift  <= {r_rx_s, r_shift[DataLength-1:1]};
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == B_LAST)
`ifdef UART_RX_PARITY_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_STOP;
`endif
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        if (r_tcnt == T_FULL) begin
                            r_tcnt    <= '0;
                            r_par_bad <= (r_rx_s != ^r_shift);
                            r_state   <= S_STOP;
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
`endif
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tcnt == T_FULL) begin
                            r_tcnt  <= '0;
                            r_state <= S_IDLE;
                            if (!r_rx_s)
                                r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            else if (r_par_bad)
                                r_parity_err <= 1'b1;
`endif
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO: extra pointer bit separates full from empty; a pop frees the slot for a simultaneous push.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_rx_req && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end

    assign o_rx_data   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_rx_rdy    = !w_empty;
    assign o_busy      = (r_state != S_IDLE);
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive path of the UART: oversamples the asynchronous `i_rx` line, deframes start/data/(parity)/stop bits and queues each good byte in a first-word-fall-through FIFO read by the host through an `i_rx_req` / `o_rx_rdy` handshake. It is the counterpart of the transmit path, uses the same frame format and baud/oversample parameters, and sits between the board pin and the register/host interface.

## Interface
- `DataLength`, 8: data bits per frame, sent LSB first.
- `FifoDepth`, 8: receive FIFO entries; must be a power of two and at least 2.
- `OverSample`, 8: ticks per bit; must be even and at least 4.
- `BaudRate`, 115200: line rate in bit/s.
- `SystemClockFreq`, 50_000_000: `i_clk` frequency in Hz.
- `i_clk`  in  1  system clock; everything is on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_rx`  in  1  serial line input; asynchronous; idles high.
- `i_rx_req`  in  1  pop request; acted on only when `o_rx_rdy` is 1.
- `o_rx_data`  out  DataLength  FIFO head; valid while `o_rx_rdy` is 1.
- `o_rx_rdy`  out  1  FIFO not empty.
- `o_busy`  out  1  the deframer is not in IDLE.
- `o_frame_err`  out  1  one-cycle pulse when a frame's stop bit samples 0.
- `o_parity_err`  out  1  one-cycle pulse on a parity mismatch; tied to 0 when parity is compiled out.
- `o_overrun`  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Synchronizer.** `i_rx` passes through two flops, both reset to 1. All logic uses the synchronized value `rx_s`.
- **Tick generator.**
  - `DIV = SystemClockFreq / (BaudRate*OverSample)`, using integer truncation; this is 54 at the defaults.
  - A counter of width `$clog2(DIV)` asserts `tick` for one cycle every `DIV` clocks.
  - The counter is cleared on the cycle IDLE detects `rx_s` = 0.
- **State machine.** States are IDLE, START, DATA, PARITY, STOP. The tick counter within a bit is `tcnt`, `$clog2(OverSample)` wide.
  - IDLE: when `rx_s` = 0, go to START and clear `tcnt`.
  - START: on the `OverSample/2`-th tick, sample `rx_s`. If it is 1 (a glitch), return to IDLE. If it is 0, clear `tcnt` and `bitcnt` and go to DATA.
  - DATA: on every `OverSample`-th tick, shift `rx_s` into the MSB of the shift register and increment `bitcnt`. After the sample with `bitcnt == DataLength-1`, go to PARITY if the macro is defined, otherwise to STOP.
  - PARITY: on the `OverSample`-th tick, compare `rx_s` with the even parity of the data and latch a mismatch flag. Go to STOP.
  - STOP: on the `OverSample`-th tick, sample `rx_s` and return to IDLE in the same cycle, so a start bit that immediately follows is caught.
    - Stop = 0: pulse `o_frame_err`; no push.
    - Stop = 1 with the parity flag set: pulse `o_parity_err`; no push.
    - Otherwise push the byte. If the FIFO is full, pulse `o_overrun` and drop the byte.
- **FIFO.**
  - Read and write pointers are `$clog2(FifoDepth)+1` bits wide; the extra bit distinguishes full from empty.
  - Empty when the pointers are equal. Full when the MSBs differ and the rest are equal.
  - `o_rx_data` is combinational from `mem[rd_ptr]`.
  - A pop occurs when `i_rx_req && o_rx_rdy`.
  - Push and pop in the same cycle:
    - FIFO full: both succeed; no overrun.
    - FIFO empty: the push succeeds and the pop is ignored.
  - `i_rx_req` while empty has no effect.
- **Reset values.** All outputs are 0 and the FSM is in IDLE. Reset mid-frame discards the partial byte and flushes the FIFO. After release, the FSM waits for the next falling edge of `rx_s`; it never re-syncs on a line that is already low.

## Timing
- Input to `rx_s`: 2 cycles.
- Bit period: `DIV*OverSample` clocks, which is 432 at the defaults.
- Push to `o_rx_rdy` high: 1 cycle, because the pointer is registered.
- End to end: `o_rx_rdy` rises about 9.5 bit periods after the falling edge of the start bit, or 10.5 with parity. This is about 4104 clocks at the defaults without parity, within ±`DIV`.
- Pop: the next head appears on `o_rx_data` the cycle after the pop edge. `o_rx_rdy` falls in that same cycle if the FIFO is now empty.
- The `o_frame_err`, `o_parity_err` and `o_overrun` pulses coincide with the STOP sample cycle.
- Tolerated baud mismatch: ±3% at `OverSample` = 8.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined: every frame carries an even-parity bit between the last data bit and stop. The PARITY state is compiled in; a mismatch pulses `o_parity_err` and the byte is not queued.
  - Undefined: the frame is start, data, stop. The PARITY state is absent and `o_parity_err` is a constant 0.

## Test plan
- **Single byte.** Reset, then drive 0xA5 at 115200 baud with default parameters → `o_rx_rdy` = 1 and `o_rx_data` = 0xA5 within 4104±54 clocks of the start edge. Pulse `i_rx_req` → `o_rx_rdy` = 0 on the next cycle.
- **Start glitch.** Drive `i_rx` low for 100 ns, then return it high → no push, no error pulse, and `o_busy` back to 0 within 4 ticks.
- **Bad stop bit.** Send 0x3C with stop bit = 0 → one `o_frame_err` pulse and `o_rx_rdy` stays 0. Then send 0x55 back-to-back → 0x55 is queued.
- **Overrun.** Send 9 bytes 0x00–0x08 with no pops → one `o_overrun` pulse on the 9th byte. Eight pops then return 0x00–0x07 in order.
- **Parity (macro defined).** Send 0x3C with a correct parity bit of 0 → queued. Send 0x3C with parity bit 1 → one `o_parity_err` pulse and nothing queued.
- **Reset mid-frame.** Assert `i_rst` during data bit 4 of 0xFF, with 2 bytes already queued → `o_rx_rdy` = 0 and `o_busy` = 0 immediately. A following 0x81 is received correctly.
